// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths and Moxie register index names
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int REG_IDX_W = 4;
   localparam int WORD_W    = 32;

   localparam logic [REG_IDX_W-1:0] REG_FP  = 4'd0;
   localparam logic [REG_IDX_W-1:0] REG_SP  = 4'd1;
   localparam logic [REG_IDX_W-1:0] REG_R0  = 4'd2;
   localparam logic [REG_IDX_W-1:0] REG_R1  = 4'd3;
   localparam logic [REG_IDX_W-1:0] REG_R2  = 4'd4;
   localparam logic [REG_IDX_W-1:0] REG_R3  = 4'd5;
   localparam logic [REG_IDX_W-1:0] REG_R4  = 4'd6;
   localparam logic [REG_IDX_W-1:0] REG_R5  = 4'd7;
   localparam logic [REG_IDX_W-1:0] REG_R6  = 4'd8;
   localparam logic [REG_IDX_W-1:0] REG_R7  = 4'd9;
   localparam logic [REG_IDX_W-1:0] REG_R8  = 4'd10;
   localparam logic [REG_IDX_W-1:0] REG_R9  = 4'd11;
   localparam logic [REG_IDX_W-1:0] REG_R10 = 4'd12;
   localparam logic [REG_IDX_W-1:0] REG_R11 = 4'd13;
   localparam logic [REG_IDX_W-1:0] REG_R12 = 4'd14;
   localparam logic [REG_IDX_W-1:0] REG_R13 = 4'd15;

endpackage

`default_nettype wire

// File: rtl/cpu_regfile_scoreboard.sv
// ============================================================================
// cpu_regfile_scoreboard : per-register pending-write counters, stall, busy
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_regfile_scoreboard
   import cpu_pkg::*;
#(
   parameter int NREGS  = 16,
   parameter int PEND_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_rel_en,
   input  logic [REG_IDX_W-1:0] i_rel_idx,
   input  logic                 i_res_en,
   input  logic [REG_IDX_W-1:0] i_res_idx,
   input  logic [REG_IDX_W-1:0] i_rd_idx1,
   input  logic [REG_IDX_W-1:0] i_rd_idx2,
   output logic                 o_stall,
   output logic                 o_busy1,
   output logic                 o_busy2,
   output logic                 o_err
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [PEND_W-1:0] r_cnt     [NREGS];
   logic [PEND_W-1:0] w_cnt_nxt [NREGS];
   logic              w_res_go;
   logic              w_underflow;
   logic              r_busy1;
   logic              r_busy2;
   logic              r_err;

   // A same-cycle release frees a slot, so a full counter can still accept.
   assign o_stall  = i_res_en && (r_cnt[i_res_idx] == CNT_MAX) &&
                     !(i_rel_en && (i_rel_idx == i_res_idx));
   assign w_res_go = i_res_en && !o_stall;

   always_comb begin
      w_underflow = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (w_res_go && (i_res_idx == REG_IDX_W'(i)) &&
             !(i_rel_en && (i_rel_idx == REG_IDX_W'(i)))) begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
         end else if (i_rel_en && (i_rel_idx == REG_IDX_W'(i)) &&
                      !(w_res_go && (i_res_idx == REG_IDX_W'(i)))) begin
            if (r_cnt[i] == '0) begin
               w_underflow = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_cnt[i] <= '0;
         end
         r_busy1 <= 1'b0;
         r_busy2 <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
         r_busy1 <= (w_cnt_nxt[i_rd_idx1] != '0);
         r_busy2 <= (w_cnt_nxt[i_rd_idx2] != '0);
         r_err   <= r_err | w_underflow;
      end
   end

   assign o_busy1 = r_busy1;
   assign o_busy2 = r_busy2;
   assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// cpu_regfile : Moxie 16x32 register file, two bypassed read ports, scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int NREGS  = 16,
   parameter int PEND_W = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [REG_IDX_W-1:0] register_write_index_i,
   input  logic                 register_write_enable_i,
   input  logic [WORD_W-1:0]    result_i,
   input  logic [REG_IDX_W-1:0] reg_read_index1_i,
   input  logic [REG_IDX_W-1:0] reg_read_index2_i,
   output logic [WORD_W-1:0]    value1_o,
   output logic [WORD_W-1:0]    value2_o,
   output logic                 busy1_o,
   output logic                 busy2_o,
   input  logic                 reserve_enable_i,
   input  logic [REG_IDX_W-1:0] reserve_index_i,
   output logic                 reserve_stall_o,
   output logic                 err_o
);

   logic [WORD_W-1:0] r_mem [NREGS];
   logic [WORD_W-1:0] r_value1;
   logic [WORD_W-1:0] r_value2;
   logic              w_hit1;
   logic              w_hit2;

   assign w_hit1 = register_write_enable_i && (register_write_index_i == reg_read_index1_i);
   assign w_hit2 = register_write_enable_i && (register_write_index_i == reg_read_index2_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
         r_value1 <= '0;
         r_value2 <= '0;
      end else begin
         if (register_write_enable_i) begin
            r_mem[register_write_index_i] <= result_i;
         end
         r_value1 <= w_hit1 ? result_i : r_mem[reg_read_index1_i];
         r_value2 <= w_hit2 ? result_i : r_mem[reg_read_index2_i];
      end
   end

   assign value1_o = r_value1;
   assign value2_o = r_value2;

   cpu_regfile_scoreboard #(
      .NREGS  (NREGS),
      .PEND_W (PEND_W)
   ) u_scoreboard (
      .clk       (clk_i),
      .rst       (rst_i),
      .i_rel_en  (register_write_enable_i),
      .i_rel_idx (register_write_index_i),
      .i_res_en  (reserve_enable_i),
      .i_res_idx (reserve_index_i),
      .i_rd_idx1 (reg_read_index1_i),
      .i_rd_idx2 (reg_read_index2_i),
      .o_stall   (reserve_stall_o),
      .o_busy1   (busy1_o),
      .o_busy2   (busy2_o),
      .o_err     (err_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_cpu_regfile.sv
// ============================================================================
// tb_cpu_regfile : directed vector table plus randomized reference-model run
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_regfile;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  register_write_index_i;
   logic        register_write_enable_i;
   logic [31:0] result_i;
   logic [3:0]  reg_read_index1_i;
   logic [3:0]  reg_read_index2_i;
   logic [31:0] value1_o;
   logic [31:0] value2_o;
   logic        busy1_o;
   logic        busy2_o;
   logic        reserve_enable_i;
   logic [3:0]  reserve_index_i;
   logic        reserve_stall_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   cpu_regfile #(.NREGS(16), .PEND_W(2)) dut (
      .clk_i                   (clk_i),
      .rst_i                   (rst_i),
      .register_write_index_i  (register_write_index_i),
      .register_write_enable_i (register_write_enable_i),
      .result_i                (result_i),
      .reg_read_index1_i       (reg_read_index1_i),
      .reg_read_index2_i       (reg_read_index2_i),
      .value1_o                (value1_o),
      .value2_o                (value2_o),
      .busy1_o                 (busy1_o),
      .busy2_o                 (busy2_o),
      .reserve_enable_i        (reserve_enable_i),
      .reserve_index_i         (reserve_index_i),
      .reserve_stall_o         (reserve_stall_o),
      .err_o                   (err_o)
   );

   typedef struct {
      logic        rst;
      logic        we;
      logic [3:0]  widx;
      logic [31:0] wdata;
      logic [3:0]  ri1;
      logic [3:0]  ri2;
      logic        re;
      logic [3:0]  ridx;
      logic        x_stall;
      logic [31:0] x_v1;
      logic [31:0] x_v2;
      logic        x_b1;
      logic        x_b2;
      logic        x_err;
   } vec_t;

   localparam int NVEC    = 22;
   localparam int NRAND   = 600;
   localparam int CNT_MAX = 3;

   int   total = 0;
   int   bad   = 0;
   vec_t tbl [NVEC];

   // Reference model state: architectural values and outstanding-write counts.
   logic [31:0] m_mem [16];
   int          m_cnt [16];
   logic        m_err;

   function automatic vec_t mk(input logic rst, input logic we, input logic [3:0] widx,
                               input logic [31:0] wdata, input logic [3:0] ri1,
                               input logic [3:0] ri2, input logic re, input logic [3:0] ridx,
                               input logic x_stall, input logic [31:0] x_v1,
                               input logic [31:0] x_v2, input logic x_b1, input logic x_b2,
                               input logic x_err);
      vec_t v;
      v.rst = rst; v.we = we; v.widx = widx; v.wdata = wdata;
      v.ri1 = ri1; v.ri2 = ri2; v.re = re; v.ridx = ridx;
      v.x_stall = x_stall; v.x_v1 = x_v1; v.x_v2 = x_v2;
      v.x_b1 = x_b1; v.x_b2 = x_b2; v.x_err = x_err;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      rst_i                   = v.rst;
      register_write_enable_i = v.we;
      register_write_index_i  = v.widx;
      result_i                = v.wdata;
      reg_read_index1_i       = v.ri1;
      reg_read_index2_i       = v.ri2;
      reserve_enable_i        = v.re;
      reserve_index_i         = v.ridx;
      #1;
      chk("stall", idx, {31'd0, reserve_stall_o}, {31'd0, v.x_stall});
      @(posedge clk_i);
      #1;
      chk("value1", idx, value1_o, v.x_v1);
      chk("value2", idx, value2_o, v.x_v2);
      chk("busy1", idx, {31'd0, busy1_o}, {31'd0, v.x_b1});
      chk("busy2", idx, {31'd0, busy2_o}, {31'd0, v.x_b2});
      chk("err", idx, {31'd0, err_o}, {31'd0, v.x_err});
      @(negedge clk_i);
   endtask

   // Fills in the expected fields of v from the model, then advances the model.
   task automatic model_step(inout vec_t v);
      logic take;
      v.x_stall = v.re && (m_cnt[v.ridx] == CNT_MAX) && !(v.we && v.widx == v.ridx);
      if (v.rst) begin
         for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = 0;
         end
         m_err  = 1'b0;
         v.x_v1 = '0; v.x_v2 = '0; v.x_b1 = 1'b0; v.x_b2 = 1'b0; v.x_err = 1'b0;
      end else begin
         v.x_v1 = (v.we && v.widx == v.ri1) ? v.wdata : m_mem[v.ri1];
         v.x_v2 = (v.we && v.widx == v.ri2) ? v.wdata : m_mem[v.ri2];
         if (v.we) m_mem[v.widx] = v.wdata;
         take = v.re && !v.x_stall;
         if (!(take && v.we && v.widx == v.ridx)) begin
            if (take) m_cnt[v.ridx] = m_cnt[v.ridx] + 1;
            if (v.we) begin
               if (m_cnt[v.widx] == 0) m_err = 1'b1;
               else m_cnt[v.widx] = m_cnt[v.widx] - 1;
            end
         end
         v.x_b1  = (m_cnt[v.ri1] != 0);
         v.x_b2  = (m_cnt[v.ri2] != 0);
         v.x_err = m_err;
      end
   endtask

   initial begin
      //            rst we widx wdata         ri1 ri2 re ridx  stall v1            v2            b1 b2 err
      tbl[0]  = mk(1, 0, 0, 32'h0,         0,  0,  0, 0,    0, 32'h0,         32'h0,         0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 32'h0,         4,  0,  1, 4,    0, 32'h0,         32'h0,         1, 0, 0);
      tbl[2]  = mk(0, 0, 0, 32'h0,         4,  0,  1, 4,    0, 32'h0,         32'h0,         1, 0, 0);
      tbl[3]  = mk(1, 1, 4, 32'h5,         4,  4,  1, 4,    0, 32'h0,         32'h0,         0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 32'h0,         4,  4,  0, 0,    0, 32'h0,         32'h0,         0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 32'h0,         5,  0,  1, 5,    0, 32'h0,         32'h0,         1, 0, 0);
      tbl[6]  = mk(0, 1, 5, 32'hDEADBEEF,  5,  5,  0, 0,    0, 32'hDEADBEEF,  32'hDEADBEEF,  0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 32'h0,         5,  0,  0, 0,    0, 32'hDEADBEEF,  32'h0,         0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 32'h0,         3,  0,  1, 3,    0, 32'h0,         32'h0,         1, 0, 0);
      tbl[9]  = mk(0, 1, 3, 32'h12,        3,  0,  0, 0,    0, 32'h12,        32'h0,         0, 0, 0);
      tbl[10] = mk(0, 0, 0, 32'h0,         7,  0,  1, 7,    0, 32'h0,         32'h0,         1, 0, 0);
      tbl[11] = mk(0, 0, 0, 32'h0,         7,  0,  1, 7,    0, 32'h0,         32'h0,         1, 0, 0);
      tbl[12] = mk(0, 0, 0, 32'h0,         7,  0,  1, 7,    0, 32'h0,         32'h0,         1, 0, 0);
      tbl[13] = mk(0, 0, 0, 32'h0,         7,  0,  1, 7,    1, 32'h0,         32'h0,         1, 0, 0);
      tbl[14] = mk(0, 1, 7, 32'hA7,        7,  0,  1, 7,    0, 32'hA7,        32'h0,         1, 0, 0);
      tbl[15] = mk(0, 0, 0, 32'h0,         7,  0,  1, 7,    1, 32'hA7,        32'h0,         1, 0, 0);
      tbl[16] = mk(0, 1, 9, 32'h99,        9,  0,  0, 0,    0, 32'h99,        32'h0,         0, 0, 1);
      tbl[17] = mk(0, 0, 0, 32'h0,         9,  9,  0, 0,    0, 32'h99,        32'h99,        0, 0, 1);
      tbl[18] = mk(0, 0, 0, 32'h0,         2,  2,  1, 2,    0, 32'h0,         32'h0,         1, 1, 1);
      tbl[19] = mk(0, 1, 2, 32'h22,        2,  2,  1, 2,    0, 32'h22,        32'h22,        1, 1, 1);
      tbl[20] = mk(0, 0, 0, 32'h0,         2,  2,  0, 0,    0, 32'h22,        32'h22,        1, 1, 1);
      tbl[21] = mk(0, 1, 2, 32'h23,        2,  7,  0, 0,    0, 32'h23,        32'hA7,        0, 1, 1);

      for (int n = 0; n < NVEC; n++) begin
         run_vec(tbl[n], n);
      end

      for (int n = 0; n < NRAND; n++) begin
         vec_t v;
         v.rst   = (n == 0) || ($urandom_range(0, 63) == 0);
         v.we    = ($urandom_range(0, 2) == 0);
         v.widx  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         v.wdata = $urandom;
         v.ri1   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         v.ri2   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         v.re    = ($urandom_range(0, 1) == 0);
         v.ridx  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         model_step(v);
         run_vec(v, NVEC + n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu_regfile.md
Name: cpu_regfile

Overview:
- Moxie general register file: 16 x 32-bit registers ($fp, $sp, $r0-$r13); index 0 is an ordinary register, not hardwired to zero.
- Terminates the writeback interface and serves two read ports to decode/execute.
- Holds a per-register pending-write scoreboard. Decode reserves a destination; the writeback commit releases it. Read ports report hazards.

Parameters:
- NREGS, 16, number of architectural registers (index width fixed at 4).
- PEND_W, 2, width of each per-register pending counter (max outstanding writes = 2^PEND_W-1).

Ports:
- clk_i  in  1  clock, all state updates on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- register_write_index_i  in  4  writeback destination index.
- register_write_enable_i  in  1  writeback commit strobe; also releases one pending count.
- result_i  in  32  writeback data.
- reg_read_index1_i  in  4  read port 1 index.
- reg_read_index2_i  in  4  read port 2 index.
- value1_o  out  32  read port 1 data, registered.
- value2_o  out  32  read port 2 data, registered.
- busy1_o  out  1  port 1 register has an outstanding write, registered with value1_o.
- busy2_o  out  1  port 2 register has an outstanding write, registered with value2_o.
- reserve_enable_i  in  1  decode claims a destination register.
- reserve_index_i  in  4  register being claimed.
- reserve_stall_o  out  1  combinational; claim cannot be accepted this cycle.
- err_o  out  1  sticky; a release occurred with counter at 0.

Behaviour:
- Reset (rst_i=1 at posedge): all 16 registers = 0; all counters = 0; value1_o/value2_o = 0; busy1_o/busy2_o = 0; err_o = 0. Reset overrides every same-cycle write, reserve or release.
- Write: on posedge with register_write_enable_i=1, mem[register_write_index_i] <= result_i.
- Read latency 1: value1_o <= mem[reg_read_index1_i], except write-through bypass. If register_write_enable_i=1 and the indices match, value1_o <= result_i. Port 2 is identical and independent. Both ports may name the same register.
- Counter next state per register i:
  - rel = register_write_enable_i && index==i
  - res = reserve_enable_i && reserve_index_i==i && !reserve_stall_o
  - res&&rel: unchanged. res only: +1. rel only: -1, or stays 0 and sets err_o if already 0.
- busyN_o <= (next-state counter of reg_read_indexN_i != 0). A release in the read cycle clears busy if the count drops to 0. A reserve in the same cycle sets busy.
- reserve_stall_o = reserve_enable_i && counter[reserve_index_i]==max && !(rel on the same index). When stalled, the counter is unchanged and decode must hold the request.
- Counters saturate and never wrap.
- err_o is sticky until reset. The write data is still committed.

Decomposition:
- Shared package cpu_pkg:
  - REG_IDX_W=4, WORD_W=32
  - register index localparams (REG_FP=0, REG_SP=1, REG_R0=2 ... REG_R13=15)
- Sub-module cpu_regfile_scoreboard: counters, stall and busy next-state logic.
- Storage array and bypass muxes stay in the top module.

Test Plan:
- Reset with pending writes outstanding: all values, busy flags and err_o read 0 one cycle after rst_i deasserts.
- Write reg 5 = 0xDEADBEEF and read index1=5 in the same cycle: value1_o=0xDEADBEEF next cycle (bypass). Read again next cycle: same value from storage.
- Reserve reg 3, then read 3: busy1_o=1. Writeback reg 3 = 0x12 while reading 3: busy1_o=0 and value1_o=0x12.
- Reserve reg 7 three times (PEND_W=2): counter=3. Fourth reserve: reserve_stall_o=1. Fourth reserve plus same-cycle release on 7: no stall, counter stays 3.
- Release reg 9 with counter 0: err_o=1 and stays 1; mem[9] still updated.
- Simultaneous reserve and release of reg 2 with counter 1: counter stays 1, busy remains 1. Port 1 and port 2 both read reg 2: identical outputs.
